arb_que_mc: RTL and testbench

ARB_QUE_MC -- requirements
Module: arb_que_mc

---
 rtl/arb_que_mc.sv | 115 +++++++++++
 tb/tb_arb_que_mc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/arb_que_mc.sv
// Multi-channel FIFO bank with round-robin pop arbitration. Head of the granted channel is shown combinationally.
// Pushes become visible one cycle after acceptance; a full channel drops pushes (sticky overflow) unless popped that cycle.
module arb_que_mc #(
  parameter  int NBITS = 8,
  parameter  int DEPTH = 4,
  parameter  int NCH   = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int SW    = $clog2(NCH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*NBITS-1:0] que_in,
  input  logic                 clear,
  input  logic                 dec,
  output logic [NBITS-1:0]     que_out,
  output logic                 que_valid,
  output logic [SW-1:0]        que_ch,
  output logic [NCH*CW-1:0]    count,
  output logic [NCH-1:0]       full,
  output logic [NCH-1:0]       empty,
  output logic [NCH-1:0]       overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [NBITS-1:0] mem_q [NCH][DEPTH];
  logic [PW-1:0]    rd_q [NCH];
  logic [PW-1:0]    rd_d [NCH];
  logic [PW-1:0]    wr_q [NCH];
  logic [PW-1:0]    wr_d [NCH];
  logic [CW-1:0]    cnt_q [NCH];
  logic [CW-1:0]    cnt_d [NCH];
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic [SW-1:0]    rr_q, rr_d;
  logic [NCH-1:0]   push, pop;
  logic [SW-1:0]    gnt;
  logic             any_vld;
  logic             found;
  int               idx;

  always_comb begin
    count = '0;
    for (int i = 0; i < NCH; i++) begin
      empty[i]            = (cnt_q[i] == '0);
      full[i]             = (cnt_q[i] == CW'(DEPTH));
      count[i*CW +: CW]   = cnt_q[i];
    end
    any_vld  = |(~empty);
    overflow = ovf_q;
  end

  // Round-robin scan upward from rr_q, wrapping modulo NCH.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_q) + k) % NCH;
      if (!found && !empty[idx]) begin
        gnt   = SW'(idx);
        found = 1'b1;
      end
    end
  end

  assign que_valid = any_vld;
  assign que_ch    = gnt;
  assign que_out   = any_vld ? mem_q[gnt][rd_q[gnt]] : '0;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pop[i]   = dec && any_vld && !clear && (gnt == SW'(i));
      push[i]  = en[i] && !clear && (!full[i] || pop[i]);
      rd_d[i]  = clear ? '0 : rd_q[i] + PW'(pop[i]);
      wr_d[i]  = clear ? '0 : wr_q[i] + PW'(push[i]);
      cnt_d[i] = clear ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      ovf_d[i] = clear ? 1'b0 : (ovf_q[i] | (en[i] & full[i] & ~pop[i]));
    end
    rr_d = rr_q;
    if (clear)
      rr_d = '0;
    else if (|pop)
      rr_d = (gnt == SW'(NCH - 1)) ? '0 : gnt + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
      rr_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        rd_q[i]  <= rd_d[i];
        wr_q[i]  <= wr_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q <= ovf_d;
      rr_q  <= rr_d;
    end
  end

  // Storage is left uncleared; pointers and counts alone define validity.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i])
        mem_q[i][wr_q[i]] <= que_in[i*NBITS +: NBITS];
    end
  end

endmodule

// File: tb/tb_arb_que_mc.sv
// Directed bench for arb_que_mc at default parameters (NBITS=8, DEPTH=4, NCH=4).
module tb_arb_que_mc;
  localparam int NBITS = 8;
  localparam int DEPTH = 4;
  localparam int NCH   = 4;
  localparam int CW    = 3;
  localparam int SW    = 2;

  logic                 CLK, RST, clear, dec;
  logic [NCH-1:0]       en;
  logic [NCH*NBITS-1:0] que_in;
  logic [NBITS-1:0]     que_out;
  logic                 que_valid;
  logic [SW-1:0]        que_ch;
  logic [NCH*CW-1:0]    count;
  logic [NCH-1:0]       full, empty, overflow;

  int n_cmp = 0;
  int n_err = 0;

  arb_que_mc #(.NBITS(NBITS), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .CLK(CLK), .RST(RST), .en(en), .que_in(que_in), .clear(clear), .dec(dec),
    .que_out(que_out), .que_valid(que_valid), .que_ch(que_ch), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_one(input int ch, input logic [7:0] val);
    que_in = '0;
    que_in[ch*NBITS +: NBITS] = val;
    en = '0;
    en[ch] = 1'b1;
    tick();
    en = '0;
  endtask

  task automatic test_reset();
    n_cmp++; if (empty !== 4'hF) begin n_err++; $display("FAIL reset_empty got %h exp %h", empty, 4'hF); end
    n_cmp++; if (full !== 4'h0) begin n_err++; $display("FAIL reset_full got %h exp %h", full, 4'h0); end
    n_cmp++; if (que_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", que_valid); end
    n_cmp++; if (que_ch !== 2'd0) begin n_err++; $display("FAIL reset_ch got %0d exp 0", que_ch); end
    n_cmp++; if (que_out !== 8'h00) begin n_err++; $display("FAIL reset_out got %h exp 00", que_out); end
    n_cmp++; if (count !== 12'h000) begin n_err++; $display("FAIL reset_count got %h exp 000", count); end
    n_cmp++; if (overflow !== 4'h0) begin n_err++; $display("FAIL reset_ovf got %h exp 0", overflow); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_out [3];
    exp_out[0] = 8'hA0; exp_out[1] = 8'hB1; exp_out[2] = 8'hC2;
    que_in = {8'h00, 8'hC2, 8'hB1, 8'hA0};
    en = 4'b0111;
    tick();
    en = '0;
    dec = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (que_out !== exp_out[k]) begin n_err++; $display("FAIL fair_out%0d got %h exp %h", k, que_out, exp_out[k]); end
      n_cmp++; if (que_ch !== SW'(k)) begin n_err++; $display("FAIL fair_ch%0d got %0d exp %0d", k, que_ch, k); end
      tick();
    end
    dec = 1'b0;
    n_cmp++; if (que_valid !== 1'b0) begin n_err++; $display("FAIL fair_valid_after got %b exp 0", que_valid); end
  endtask

  task automatic test_full_overflow();
    for (int k = 1; k <= 5; k++) begin
      push_one(3, 8'(k));
      if (k == 4) begin
        n_cmp++; if (full[3] !== 1'b1) begin n_err++; $display("FAIL full3_after4 got %b exp 1", full[3]); end
        n_cmp++; if (overflow[3] !== 1'b0) begin n_err++; $display("FAIL ovf3_early got %b exp 0", overflow[3]); end
      end
    end
    n_cmp++; if (overflow[3] !== 1'b1) begin n_err++; $display("FAIL ovf3 got %b exp 1", overflow[3]); end
    n_cmp++; if (count[3*CW +: CW] !== 3'd4) begin n_err++; $display("FAIL cnt3_after5 got %0d exp 4", count[3*CW +: CW]); end
    dec = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (que_out !== 8'(k)) begin n_err++; $display("FAIL ovf_pop%0d got %h exp %h", k, que_out, 8'(k)); end
      n_cmp++; if (que_ch !== 2'd3) begin n_err++; $display("FAIL ovf_ch%0d got %0d exp 3", k, que_ch); end
      tick();
    end
    dec = 1'b0;
    n_cmp++; if (empty !== 4'hF) begin n_err++; $display("FAIL ovf_drain_empty got %h exp F", empty); end
    n_cmp++; if (overflow[3] !== 1'b1) begin n_err++; $display("FAIL ovf3_sticky got %b exp 1", overflow[3]); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (overflow !== 4'h0) begin n_err++; $display("FAIL ovf_cleared got %h exp 0", overflow); end
  endtask

  task automatic test_simul_full();
    logic [7:0] exp_out [4];
    for (int k = 0; k < 4; k++) push_one(0, 8'h10 + 8'(k));
    n_cmp++; if (full[0] !== 1'b1) begin n_err++; $display("FAIL sim_full0 got %b exp 1", full[0]); end
    que_in = '0;
    que_in[7:0] = 8'h55;
    en = 4'b0001;
    dec = 1'b1;
    #1;
    n_cmp++; if (que_out !== 8'h10) begin n_err++; $display("FAIL sim_head got %h exp 10", que_out); end
    tick();
    en = '0;
    n_cmp++; if (count[CW-1:0] !== 3'd4) begin n_err++; $display("FAIL sim_cnt0 got %0d exp 4", count[CW-1:0]); end
    n_cmp++; if (overflow[0] !== 1'b0) begin n_err++; $display("FAIL sim_ovf0 got %b exp 0", overflow[0]); end
    exp_out[0] = 8'h11; exp_out[1] = 8'h12; exp_out[2] = 8'h13; exp_out[3] = 8'h55;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (que_out !== exp_out[k]) begin n_err++; $display("FAIL sim_pop%0d got %h exp %h", k, que_out, exp_out[k]); end
      tick();
    end
    dec = 1'b0;
    n_cmp++; if (empty[0] !== 1'b1) begin n_err++; $display("FAIL sim_empty0 got %b exp 1", empty[0]); end
  endtask

  task automatic test_clear_priority();
    // rr is 1 here; ch0=3, ch1=0, ch2=1, ch3=2
    que_in = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    en = 4'b1101; tick();
    en = 4'b1001; tick();
    en = 4'b0001; tick();
    en = '0;
    n_cmp++; if (count !== {3'd2, 3'd1, 3'd0, 3'd3}) begin n_err++; $display("FAIL clr_pre_count got %h exp %h", count, {3'd2, 3'd1, 3'd0, 3'd3}); end
    clear = 1'b1; en = 4'b1111; dec = 1'b1;
    tick();
    clear = 1'b0; en = '0; dec = 1'b0;
    n_cmp++; if (count !== 12'h000) begin n_err++; $display("FAIL clr_count got %h exp 000", count); end
    n_cmp++; if (overflow !== 4'h0) begin n_err++; $display("FAIL clr_ovf got %h exp 0", overflow); end
    n_cmp++; if (que_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got %b exp 0", que_valid); end
    que_in = {8'h00, 8'h00, 8'h61, 8'h60};
    en = 4'b0011; tick(); en = '0;
    n_cmp++; if (que_ch !== 2'd0) begin n_err++; $display("FAIL clr_rr got %0d exp 0", que_ch); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_async_reset();
    push_one(1, 8'h31);
    push_one(1, 8'h32);
    n_cmp++; if (count[CW +: CW] !== 3'd2) begin n_err++; $display("FAIL ar_pre_cnt1 got %0d exp 2", count[CW +: CW]); end
    #2;
    RST = 1'b1;
    #1;
    n_cmp++; if (empty !== 4'hF) begin n_err++; $display("FAIL ar_empty got %h exp F", empty); end
    n_cmp++; if (que_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b exp 0", que_valid); end
    RST = 1'b0;
    push_one(2, 8'h77);
    n_cmp++; if (count[2*CW +: CW] !== 3'd1) begin n_err++; $display("FAIL ar_post_cnt2 got %0d exp 1", count[2*CW +: CW]); end
    n_cmp++; if (que_out !== 8'h77) begin n_err++; $display("FAIL ar_post_out got %h exp 77", que_out); end
    n_cmp++; if (que_ch !== 2'd2) begin n_err++; $display("FAIL ar_post_ch got %0d exp 2", que_ch); end
    dec = 1'b1; tick(); dec = 1'b0;
  endtask

  task automatic test_idle_dec_wrap();
    // rr is 3 after popping ch2
    dec = 1'b1; tick(); dec = 1'b0;
    n_cmp++; if (empty !== 4'hF) begin n_err++; $display("FAIL idle_empty got %h exp F", empty); end
    n_cmp++; if (count !== 12'h000) begin n_err++; $display("FAIL idle_count got %h exp 000", count); end
    que_in = {8'hF0, 8'hE0, 8'h00, 8'h00};
    en = 4'b1100; tick(); en = '0;
    n_cmp++; if (que_ch !== 2'd3) begin n_err++; $display("FAIL idle_rr got %0d exp 3", que_ch); end
    dec = 1'b1; tick();
    n_cmp++; if (que_out !== 8'hE0) begin n_err++; $display("FAIL idle_next got %h exp E0", que_out); end
    tick(); dec = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push_one(2, 8'h20 + 8'(k));
      n_cmp++; if (que_out !== 8'h20 + 8'(k)) begin n_err++; $display("FAIL wrap_out%0d got %h exp %h", k, que_out, 8'h20 + 8'(k)); end
      n_cmp++; if (que_ch !== 2'd2) begin n_err++; $display("FAIL wrap_ch%0d got %0d exp 2", k, que_ch); end
      dec = 1'b1; tick(); dec = 1'b0;
      n_cmp++; if (empty[2] !== 1'b1) begin n_err++; $display("FAIL wrap_empty%0d got %b exp 1", k, empty[2]); end
    end
  endtask

  initial begin
    RST = 1'b1; clear = 1'b0; dec = 1'b0; en = '0; que_in = '0;
    #12;
    test_reset();
    RST = 1'b0;
    tick();
    test_fairness();
    test_full_overflow();
    test_simul_full();
    test_clear_priority();
    test_async_reset();
    test_idle_dec_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
